// File: rtl/tri_accum_loop.sv
// tri_accum_loop: restartable triangular/stride accumulation loop (i += 1|step, j += i) with saturation stop.
// Optional assertion checks compiled in with TRI_ACCUM_ASSERT_EN. Revision: 1.0
`default_nettype none

module tri_accum_loop #(
  parameter int W       = 13,
  parameter int N_INIT  = 100,
  parameter int K_INIT  = 80,
  parameter int J_LIMIT = 4855
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] n_in,
  input  logic [W-1:0] k_in,
  input  logic [W-1:0] step_in,
  output logic [W-1:0] i,
  output logic [W-1:0] j,
  output logic [W-1:0] k,
  output logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic         sat
);

  localparam logic [1:0]   S_IDLE = 2'd0;
  localparam logic [1:0]   S_RUN  = 2'd1;
  localparam logic [1:0]   S_DONE = 2'd2;
  localparam logic [W-1:0] N_RST  = W'(N_INIT);
  localparam logic [W-1:0] K_RST  = W'(K_INIT);
  localparam logic [W-1:0] J_LIM  = W'(J_LIMIT);

  logic [1:0]   state;
  logic [1:0]   state_nxt;
  logic         run_mode;
  logic [W-1:0] run_step;
  logic [W-1:0] inc;
  logic [W-1:0] i_sum;
  logic [W-1:0] j_sum;
  logic         cy_i;
  logic         cy_j;
  logic         cont;
  logic         cy;

  assign inc          = run_mode ? run_step : W'(1);
  assign {cy_i, i_sum} = {1'b0, i} + {1'b0, inc};
  assign {cy_j, j_sum} = {1'b0, j} + {1'b0, i};
  assign cont         = (i <= n) && (j <= J_LIM);
  assign cy           = cy_i || cy_j;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
      S_RUN:          if (!cont || cy) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_RUN);
    done = (state == S_DONE);
  end

  // A carrying update is suppressed entirely so the last good values stay visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      i        <= '0;
      j        <= '0;
      k        <= K_RST;
      n        <= N_RST;
      sat      <= 1'b0;
      run_mode <= 1'b0;
      run_step <= W'(1);
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            n        <= n_in;
            k        <= k_in;
            run_step <= step_in;
            run_mode <= mode;
            i        <= '0;
            j        <= '0;
            sat      <= 1'b0;
          end
        end
        S_RUN: begin
          if (cont && !cy) begin
            i <= i_sum;
            j <= j_sum;
          end else if (cont) begin
            sat <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef TRI_ACCUM_ASSERT_EN
  logic [W-1:0] i_prev;
  logic         run_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_prev   <= '0;
      run_prev <= 1'b0;
    end else begin
      i_prev   <= i;
      run_prev <= (state == S_RUN);
      if (done && !sat) assert ((i > n) || (j > J_LIM));
      if ((state == S_RUN) && run_prev) assert (i >= i_prev);
    end
  end
`else
  // No checking logic in this build.
`endif

endmodule

`default_nettype wire

// File: doc/tri_accum_loop.md
# tri_accum_loop

Parametrised, restartable triangular/stride accumulation loop engine. After a start request it runs a bounded loop that advances an index `i` and accumulates `j += i` while `i <= n` and `j <= J_LIMIT`. It supports loadable bounds, a selectable stride mode, a start/busy/done handshake and overflow saturation detection. It is the generalised successor of the fixed 13-bit bounded arithmetic loop cases and serves as a property-mining target inside the simple-arithmetic test suite.

## Interface
- `W`, 13, datapath width of `i`, `j`, `k`, `n`, `step`
- `N_INIT`, 100, reset value of `n`
- `K_INIT`, 80, reset value of `k`
- `J_LIMIT`, 4855, inclusive upper bound on `j` for loop continuation (unsigned, W bits)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request to load operands and begin a run
- `mode`  in  1  0 = triangular (`i += 1`), 1 = stride (`i += step`); latched at start
- `n_in`  in  W  loop bound, latched at start
- `k_in`  in  W  passive operand, latched at start
- `step_in`  in  W  stride, latched at start (used when `mode`=1)
- `i`, `j`, `k`, `n`  out  W each  registered loop state
- `busy`  out  1  high in RUN
- `done`  out  1  high in DONE
- `sat`  out  1  run ended on arithmetic carry-out

## Operation
- States: IDLE, RUN, DONE.
- Reset values: `i`=0, `j`=0, `k`=K_INIT, `n`=N_INIT, `busy`=0, `done`=0, `sat`=0, state IDLE, latched mode 0, step 1.
- IDLE or DONE with `start`=1: load `n`←`n_in`, `k`←`k_in`, step←`step_in`, mode←`mode`; clear `i`, `j`, `sat`; go to RUN.
- RUN, per cycle, evaluated on current registers:
  - cont = (`i` <= `n`) && (`j` <= J_LIMIT), unsigned.
  - inc = 1 (mode 0) or step (mode 1).
  - cy = carry out of W-bit `i`+inc or of W-bit `j`+`i`.
  - If cont && !cy: `i`←`i`+inc and `j`←`j`+`i` (old `i`), computed simultaneously. Stay in RUN.
  - If !cont: go to DONE with registers held, `sat`=0.
  - If cont && cy: go to DONE with registers held (no wrap), `sat`=1.
- `k` and `n` never change outside a start load.
- `start` is ignored in RUN.
- Step 0 in mode 1 with `j` never growing past J_LIMIT loops until reset. This is legal and must not hang the checker.
- `rst` overrides everything, including mid-RUN.

## Timing
- Start is sampled at edge E0. `busy`=1 from E0.
- Each successful update occupies one cycle.
- The failing evaluation takes one further cycle: after U updates, `done`=1 and `busy`=0 at edge E0+U+1.
- `done` and `sat` are levels held until the next accepted start or reset.
- Restart from DONE: `done` drops at the same edge `busy` rises.

## Configuration
- `TRI_ACCUM_ASSERT_EN` defined:
  - Compiles in an immediate assertion checked every cycle: when `done` && !`sat`, then (`i` > `n`) || (`j` > J_LIMIT).
  - Compiles in a second assertion: in RUN, `i` never decreases.
- Undefined: no assertion logic. Functional behaviour is identical.

## Test plan
- Reset with no start -> `i`=0, `j`=0, `k`=80, `n`=100, `busy`=0, `done`=0, `sat`=0 held indefinitely.
- Start with `n_in`=100, `k_in`=80, mode 0, W=13 -> 100 updates, `done` at E0+101, `i`=100, `j`=4950 (exit on `j`>4855), `sat`=0.
- Start with `n_in`=3, mode 0 -> states (1,0), (2,1), (3,3), (4,6), `done` at E0+5, `i`=4, `j`=6.
- Start with `n_in`=10, `step_in`=4, mode 1 -> (4,0), (8,4), (12,12), `done` at E0+4; then `start` with `n_in`=3 restarts cleanly.
- W=8, J_LIMIT=255, `n_in`=255, mode 0 -> 23 updates to `i`=23, `j`=253; next `j`+`i` carries, giving `done` with `sat`=1 and values held.
- `rst` asserted mid-run at `i`=50 -> next edge all reset values; `start` pulsed during RUN -> ignored, run result unchanged.
